mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single-port `mainMemory` word store. It shares the memory between the instruction-fetch port (I, read-only) and the load/store port (D, read/write). It serialises their requests, drives the memory strobes with one access in flight at a time, and returns read data with a one-cycle acknowledge pulse. It sits between the fetch/MEM pipeline stages and `mainMemory`.

## Interface
Parameters:
- `MEM_WORDS`, 41: number of implemented words; legal addresses are 0..MEM_WORDS-1.
- `ADDR_W`, 10: address width, matching the memory address port.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `i_req` in 1: fetch request, level; held until `i_ack`.
- `i_addr` in ADDR_W: fetch word address.
- `i_ack` out 1: one-cycle completion pulse for the I port.
- `i_rdata` out 32: fetch data; held until the next I completion.
- `i_err` out 1: pulses with `i_ack` when `i_addr` is out of range.
- `d_req` in 1: data request, level; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in 32: write data.
- `d_ack` out 1: one-cycle completion pulse for the D port.
- `d_rdata` out 32: load data; held until the next D read completion.
- `d_err` out 1: pulses with `d_ack` when `d_addr` is out of range.
- `mem_address` out ADDR_W: memory address.
- `mem_data_in` out 32: memory write data.
- `MemWrite` out 1: memory write strobe.
- `MemRead` out 1: memory read strobe.
- `mem_data_out` in 32: memory read data, valid in the cycle after `MemRead` is high.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `conflict_count` out 16: saturating count of cycles where both requests are sampled together in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Requests are sampled only in IDLE. The chosen port's address, write-enable, write data and identity are latched at the sampling edge.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port *not* granted most recently wins (round-robin).
  - `last_grant` updates on every grant, including error grants. Reset value is I, so D wins the first conflict.
- IDLE transitions:
  - Granted request in range: go to ISSUE.
  - Granted request out of range (addr >= MEM_WORDS): go directly to DONE with the err flag set. No memory strobes are issued for this request.
- ISSUE:
  - Drive `mem_address` with the latched address.
  - For a write, drive `MemWrite`=1 and `mem_data_in` with the latched data, then go to DONE.
  - For a read, drive `MemRead`=1, then go to WAIT.
- WAIT: capture `mem_data_out` into the granted port's rdata register, then go to DONE.
- DONE: assert the granted port's ack (and err, if flagged) for exactly this cycle, then go to IDLE.
- Error completions return rdata = 0 to the granted port. A D-port write completion leaves `d_rdata` unchanged.
- `MemWrite`/`MemRead` are high only in ISSUE, and never both high. In every other state, `mem_address` and `mem_data_in` hold their last values.
- `conflict_count` increments in any IDLE cycle where `i_req` and `d_req` are both 1. It saturates at 0xFFFF.
- The I port never writes; `d_we` is ignored on I grants.
- Reset (`reset_n`=0 at an edge), including mid-transaction:
  - State goes to IDLE.
  - All acks, errs and strobes go to 0. `busy` goes to 0.
  - `i_rdata`, `d_rdata` and `conflict_count` go to 0. `last_grant` goes to I.
  - The in-flight transaction is dropped without an ack. A write already strobed in ISSUE stays in memory.

## Timing
- Let E0 be the IDLE edge that samples the request.
- In-range read: strobe in cycle E0+1, data captured at E2, ack high in cycle E2+1. The next sample occurs at E4.
- In-range write: strobe in cycle E0+1, ack high in cycle E1+1. The next sample occurs at E3.
- Out-of-range access: ack and err high in cycle E0+1. The next sample occurs at E2.
- Requester rules:
  - Deassert `req` or present a new request in the cycle after ack.
  - `req` seen in DONE is not sampled.
  - A `req` still high at the following IDLE edge is a new transaction.
- Request fields are don't-care after the sampling edge.

## Test plan
- Single D write, then read: write addr 5, data 0xDEADBEEF. `MemWrite` is high exactly 1 cycle, `d_ack` 2 cycles after sampling. The read of addr 5 returns `d_rdata`=0xDEADBEEF with `d_ack` 3 cycles after sampling.
- Simultaneous `i_req` and `d_req` held, reading addr 1 and addr 2: grant order is D, I, D, I. No cycle has both acks high. `conflict_count` increments once per simultaneous IDLE sample.
- Fetch from addr 41 (`MEM_WORDS`=41): `i_ack` and `i_err` are high together 1 cycle after sampling, `i_rdata`=0, and no `MemRead`/`MemWrite` pulse occurs. Addr 40 reads normally.
- Assert `reset_n`=0 while in WAIT for a D read: the next cycle has `busy`=0, `d_ack`=0 and `d_rdata`=0. Re-issuing the read completes normally.
- Hold both requests for 70000 cycles: `conflict_count` stops at 0xFFFF and does not wrap.
- Back-to-back I reads of addr 0 then 3, with `i_req` held continuously: two `i_ack` pulses 4 cycles apart, with the correct data on each.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer for the single-port main memory.
// One access in flight; round-robin on conflicts; out-of-range requests complete with err and no strobes.
module mem_arbiter #(
    parameter int          MEM_WORDS    = 41,
    parameter int          ADDR_W       = 10,
    parameter logic [15:0] CONFLICT_SAT = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       mem_data_out,

    output logic              busy,
    output logic [15:0]       conflict_count
);

    // state | meaning
    // IDLE  | sample requests, arbitrate, latch the winner
    // ISSUE | drive one memory strobe for the latched access
    // WAIT  | capture read data into the granted port's rdata
    // DONE  | one-cycle ack (and err) to the granted port
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS);

    state_t            state_q, state_d;
    logic              port_d_q;       // 1 = D port owns the current access
    logic              last_grant_d_q; // 1 = D was granted most recently
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [31:0]       mem_data_in_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic [15:0]       conflict_q;

    logic              both_req;
    logic              any_req;
    logic              grant_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_err;

    always_comb begin
        both_req = i_req & d_req;
        any_req  = i_req | d_req;
        grant_d  = both_req ? ~last_grant_d_q : d_req;
        sel_addr = grant_d ? d_addr : i_addr;
        sel_we   = grant_d & d_we;
        sel_err  = (sel_addr >= ADDR_LIMIT);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = sel_err ? DONE : ISSUE;
            ISSUE:   state_d = we_q ? DONE : WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            port_d_q       <= 1'b0;
            last_grant_d_q <= 1'b0;
            we_q           <= 1'b0;
            err_q          <= 1'b0;
            mem_address_q  <= '0;
            mem_data_in_q  <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            conflict_q     <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (both_req && conflict_q != CONFLICT_SAT) begin
                    conflict_q <= conflict_q + 16'd1;
                end
                if (any_req) begin
                    port_d_q       <= grant_d;
                    last_grant_d_q <= grant_d;
                    we_q           <= sel_we;
                    err_q          <= sel_err;
                    // memory-side registers only move for real accesses so they hold otherwise
                    if (sel_err) begin
                        if (grant_d) d_rdata_q <= '0;
                        else         i_rdata_q <= '0;
                    end else begin
                        mem_address_q <= sel_addr;
                        if (sel_we) mem_data_in_q <= d_wdata;
                    end
                end
            end
            if (state_q == WAIT) begin
                if (port_d_q) d_rdata_q <= mem_data_out;
                else          i_rdata_q <= mem_data_out;
            end
        end
    end

    always_comb begin
        MemWrite       = 1'b0;
        MemRead        = 1'b0;
        i_ack          = 1'b0;
        d_ack          = 1'b0;
        i_err          = 1'b0;
        d_err          = 1'b0;
        busy           = (state_q != IDLE);
        mem_address    = mem_address_q;
        mem_data_in    = mem_data_in_q;
        i_rdata        = i_rdata_q;
        d_rdata        = d_rdata_q;
        conflict_count = conflict_q;
        if (state_q == ISSUE) begin
            MemWrite = we_q;
            MemRead  = ~we_q;
        end
        if (state_q == DONE) begin
            i_ack = ~port_d_q;
            d_ack = port_d_q;
            i_err = ~port_d_q & err_q;
            d_err = port_d_q & err_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level timing model.
// Interval k is the clock period after rising edge k; outputs are checked at its falling edge.
module tb_mem_arbiter;

    localparam int          MEM_WORDS = 41;
    localparam int          ADDR_W    = 10;
    localparam logic [15:0] CSAT      = 16'd200;

    logic              clock;
    logic              reset_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              MemWrite;
    logic              MemRead;
    logic [31:0]       mem_data_out;
    logic              busy;
    logic [15:0]       conflict_count;

    mem_arbiter #(
        .MEM_WORDS   (MEM_WORDS),
        .ADDR_W      (ADDR_W),
        .CONFLICT_SAT(CSAT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_ack         (i_ack),
        .i_rdata       (i_rdata),
        .i_err         (i_err),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_ack         (d_ack),
        .d_rdata       (d_rdata),
        .d_err         (d_err),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .mem_data_out  (mem_data_out),
        .busy          (busy),
        .conflict_count(conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory stub: write on strobe edge, read data valid the cycle after MemRead
    logic [31:0] mem_stub [0:1023];
    always @(posedge clock) begin
        if (MemWrite) mem_stub[mem_address] <= mem_data_in;
        if (MemRead)  mem_data_out <= mem_stub[mem_address];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (interval %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                we;
        logic [31:0]       wdata;
    } req_t;

    req_t iq[$];
    req_t dq[$];
    bit   i_act = 0;
    bit   d_act = 0;

    // reference model state
    logic [31:0]       ref_mem [0:1023];
    int                next_sample;
    bit                last_d;
    int                cnt_model;
    bit                p_valid;
    bit                p_port_d;
    bit                p_we;
    bit                p_err;
    int                p_s;
    int                p_ack;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0]       p_wdata;
    logic [31:0]       p_rdata;
    logic [31:0]       exp_i_rdata;
    logic [31:0]       exp_d_rdata;

    int rst_edges    = 2;
    bit rst_wait_arm = 0;

    task automatic model_reset(input int e);
        p_valid     = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        cnt_model   = 0;
        last_d      = 0;
        next_sample = e + 1;
    endtask

    // What the arbiter does at rising edge e, given the inputs now being driven.
    task automatic model_edge(input int e);
        bit gd;
        bit we;
        bit err;
        int lat;
        logic [ADDR_W-1:0] a;
        if (!reset_n) begin
            model_reset(e);
        end else if (e == next_sample) begin
            if (i_req && d_req && cnt_model < int'(CSAT)) cnt_model++;
            if (!i_req && !d_req) begin
                next_sample = e + 1;
            end else begin
                gd      = (i_req && d_req) ? !last_d : d_req;
                last_d  = gd;
                a       = gd ? d_addr : i_addr;
                we      = gd && d_we;
                err     = (int'(a) >= MEM_WORDS);
                lat     = err ? 1 : (we ? 2 : 3);
                p_valid = 1;
                p_port_d = gd;
                p_we    = we;
                p_err   = err;
                p_s     = e;
                p_ack   = e + lat - 1;
                p_addr  = a;
                p_wdata = d_wdata;
                p_rdata = err ? 32'h0 : ref_mem[a];
                if (!err && we) ref_mem[a] = d_wdata;
                next_sample = e + lat + 1;
            end
        end
    endtask

    task automatic do_checks(input int k);
        bit in_tx;
        bit at_ack;
        bit strobe;
        in_tx  = p_valid && k >= p_s && k <= p_ack;
        at_ack = p_valid && k == p_ack;
        strobe = p_valid && k == p_s && !p_err;
        if (at_ack) begin
            if (!p_port_d)              exp_i_rdata = p_rdata;
            else if (p_err || !p_we)    exp_d_rdata = p_rdata;
        end
        chk_val("busy",     32'(busy),     32'(in_tx));
        chk_val("i_ack",    32'(i_ack),    32'(at_ack && !p_port_d));
        chk_val("d_ack",    32'(d_ack),    32'(at_ack && p_port_d));
        chk_val("i_err",    32'(i_err),    32'(at_ack && !p_port_d && p_err));
        chk_val("d_err",    32'(d_err),    32'(at_ack && p_port_d && p_err));
        chk_val("MemRead",  32'(MemRead),  32'(strobe && !p_we));
        chk_val("MemWrite", 32'(MemWrite), 32'(strobe && p_we));
        chk_val("i_rdata",  i_rdata, exp_i_rdata);
        chk_val("d_rdata",  d_rdata, exp_d_rdata);
        chk_val("conflict_count", 32'(conflict_count), 32'(cnt_model));
        if (strobe) begin
            chk_val("mem_address", 32'(mem_address), 32'(p_addr));
            if (p_we) chk_val("mem_data_in", mem_data_in, p_wdata);
        end
    endtask

    task automatic agents(input int k);
        bit at_ack;
        at_ack = p_valid && k == p_ack;
        if (i_act && at_ack && !p_port_d) begin
            void'(iq.pop_front());
            i_act = 0;
        end
        if (d_act && at_ack && p_port_d) begin
            void'(dq.pop_front());
            d_act = 0;
        end
        if (!i_act && iq.size() > 0) i_act = 1;
        if (!d_act && dq.size() > 0) d_act = 1;
        i_req = i_act;
        if (i_act) i_addr = iq[0].addr;
        else       i_addr = ADDR_W'($urandom);
        d_req = d_act;
        if (d_act) begin
            d_addr  = dq[0].addr;
            d_we    = dq[0].we;
            d_wdata = dq[0].wdata;
        end else begin
            d_addr  = ADDR_W'($urandom);
            d_we    = 1'($urandom);
            d_wdata = $urandom;
        end
    endtask

    // engine: check interval, advance requesters, decide reset, predict the next edge
    initial begin
        reset_n = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_we    = 1'b0;
        d_wdata = '0;
        model_reset(0);
        forever begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            do_checks(cyc);
            agents(cyc);
            if (rst_wait_arm && p_valid && p_port_d && !p_we && !p_err && cyc == p_s + 1) begin
                rst_edges    = 1;
                rst_wait_arm = 0;
            end
            if (rst_edges > 0) begin
                reset_n = 1'b0;
                rst_edges--;
            end else begin
                reset_n = 1'b1;
            end
            model_edge(cyc + 1);
        end
    end

    task automatic push_i(input int a);
        req_t r;
        r.addr  = ADDR_W'(a);
        r.we    = 1'b0;
        r.wdata = '0;
        iq.push_back(r);
    endtask

    task automatic push_d(input int a, input bit we, input logic [31:0] wd);
        req_t r;
        r.addr  = ADDR_W'(a);
        r.we    = we;
        r.wdata = wd;
        dq.push_back(r);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (iq.size() == 0 && dq.size() == 0 && !i_act && !d_act) break;
        end
        left = iq.size() + dq.size();
        chk_val(tag, 32'(left), 32'd0);
        repeat (3) @(negedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) begin
            v           = $urandom;
            mem_stub[i] = v;
            ref_mem[i]  = v;
        end
        repeat (6) @(negedge clock);
        #1;

        push_d(5, 1'b1, 32'hDEADBEEF);
        push_d(5, 1'b0, 32'h0);
        wait_drain("drain_wr_rd", 50);

        push_i(1);
        push_i(1);
        push_d(2, 1'b0, 32'h0);
        push_d(2, 1'b0, 32'h0);
        wait_drain("drain_conflict", 60);

        push_i(41);
        push_i(40);
        wait_drain("drain_range", 50);

        rst_wait_arm = 1;
        push_d(5, 1'b0, 32'h0);
        wait_drain("drain_reset_wait", 60);
        chk_val("reset_fired", 32'(rst_wait_arm), 32'd0);

        push_i(0);
        push_i(3);
        wait_drain("drain_b2b", 50);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) push_i(int'($urandom_range(0, 47)));
            else push_d(int'($urandom_range(0, 47)), 1'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) @(negedge clock);
                #1;
            end
        end
        wait_drain("drain_random", 3000);

        for (int n = 0; n < 260; n++) begin
            push_i(int'($urandom_range(0, MEM_WORDS - 1)));
            push_d(int'($urandom_range(0, MEM_WORDS - 1)), 1'b0, 32'h0);
        end
        wait_drain("drain_saturate", 4000);
        chk_val("conflict_sat", 32'(conflict_count), 32'(CSAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
